fp_align_add: RTL and testbench

//  Multi-cycle FP significand align + add/sub stage, directly upstream of mantissa normaliser.

---
 rtl/fp_align_add_if.sv | 30 +++
 rtl/fp_align_add.sv | 187 ++++++++++++++++++
 tb/tb_fp_align_add.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fp_align_add_if.sv
// Handshake and operand/result bundle for fp_align_add.
// slave = the align/add stage, master = the upstream/downstream side driving it.
interface fp_align_add_if #(
  parameter int unsigned MAN_W = 23,
  parameter int unsigned EXP_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_man;
  logic             b_sign;
  logic [EXP_W-1:0] b_exp;
  logic [MAN_W-1:0] b_man;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [MAN_W+2:0] out_val;
  logic [EXP_W-1:0] out_exp;

  modport slave (
    input  in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, sub, out_ready,
    output in_ready, out_valid, out_val, out_exp
  );

  modport master (
    output in_valid, a_sign, a_exp, a_man, b_sign, b_exp, b_man, sub, out_ready,
    input  in_ready, out_valid, out_val, out_exp
  );
endinterface

// File: rtl/fp_align_add.sv
// Multi-cycle FP significand align (1 bit/cycle) + add/sub, emitting {zero,sign,carry,man}.
// Define FP_ALIGN_STICKY_EN to OR shifted-out bits into Y.man[0] before the add.
module fp_align_add #(
  parameter int unsigned MAN_W = 23,
  parameter int unsigned EXP_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_align_add_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  localparam logic [EXP_W:0] LP_MAN_W = (EXP_W+1)'(MAN_W);

  state_t           r_state;
  state_t           w_next;

  logic [MAN_W-1:0] r_x_man;
  logic [MAN_W-1:0] r_y_man;
  logic [EXP_W-1:0] r_x_exp;
  logic             r_x_sign;
  logic             r_y_sign;
  logic [EXP_W-1:0] r_d;
  logic             r_out_valid;
  logic [MAN_W+2:0] r_out_val;
  logic [EXP_W-1:0] r_out_exp;
`ifdef FP_ALIGN_STICKY_EN
  logic             r_sticky;
`endif

  logic [EXP_W-1:0] w_a_exp;
  logic [EXP_W-1:0] w_b_exp;
  logic             w_b_eff_sign;
  logic             w_a_ge_b;
  logic [EXP_W-1:0] w_x_exp;
  logic [EXP_W-1:0] w_y_exp;
  logic [MAN_W-1:0] w_x_man;
  logic [MAN_W-1:0] w_y_man;
  logic             w_x_sign;
  logic             w_y_sign;
  logic [EXP_W-1:0] w_diff;
  logic             w_accept;
  logic             w_big;
  logic [MAN_W-1:0] w_y_add;
  logic [MAN_W:0]   w_sum;
  logic             w_zero;
  logic [MAN_W+2:0] w_result;

  // Zero significand means a zero operand regardless of its exponent field.
  assign w_a_exp      = (bus.a_man == '0) ? '0 : bus.a_exp;
  assign w_b_exp      = (bus.b_man == '0) ? '0 : bus.b_exp;
  assign w_b_eff_sign = bus.b_sign ^ bus.sub;
  assign w_a_ge_b     = {w_a_exp, bus.a_man} >= {w_b_exp, bus.b_man};

  assign w_x_exp  = w_a_ge_b ? w_a_exp      : w_b_exp;
  assign w_y_exp  = w_a_ge_b ? w_b_exp      : w_a_exp;
  assign w_x_man  = w_a_ge_b ? bus.a_man    : bus.b_man;
  assign w_y_man  = w_a_ge_b ? bus.b_man    : bus.a_man;
  assign w_x_sign = w_a_ge_b ? bus.a_sign   : w_b_eff_sign;
  assign w_y_sign = w_a_ge_b ? w_b_eff_sign : bus.a_sign;
  assign w_diff   = w_x_exp - w_y_exp;

  assign w_accept = bus.in_valid && (r_state == IDLE);
  assign w_big    = {1'b0, r_d} > LP_MAN_W;

`ifdef FP_ALIGN_STICKY_EN
  assign w_y_add = r_y_man | {{(MAN_W-1){1'b0}}, r_sticky};
`else
  assign w_y_add = r_y_man;
`endif

  always_comb begin
    w_sum = '0;
    if (r_x_sign == r_y_sign) begin
      w_sum = {1'b0, r_x_man} + {1'b0, w_y_add};
    end else begin
      w_sum = {1'b0, r_x_man} - {1'b0, w_y_add};
    end
  end

  assign w_zero   = (w_sum == '0);
  assign w_result = {w_zero, r_x_sign & ~w_zero, w_sum};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next = (w_diff == '0) ? ADD : ALIGN;
        end
      end
      ALIGN: begin
        if (w_big || (r_d == EXP_W'(1))) begin
          w_next = ADD;
        end
      end
      ADD: begin
        w_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x_man     <= '0;
      r_y_man     <= '0;
      r_x_exp     <= '0;
      r_x_sign    <= 1'b0;
      r_y_sign    <= 1'b0;
      r_d         <= '0;
      r_out_valid <= 1'b0;
      r_out_val   <= '0;
      r_out_exp   <= '0;
`ifdef FP_ALIGN_STICKY_EN
      r_sticky    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x_man  <= w_x_man;
            r_y_man  <= w_y_man;
            r_x_exp  <= w_x_exp;
            r_x_sign <= w_x_sign;
            r_y_sign <= w_y_sign;
            r_d      <= w_diff;
`ifdef FP_ALIGN_STICKY_EN
            r_sticky <= 1'b0;
`endif
          end
        end
        ALIGN: begin
          // Shifts beyond the significand width collapse into a single zeroing cycle.
          if (w_big) begin
            r_y_man  <= '0;
            r_d      <= '0;
`ifdef FP_ALIGN_STICKY_EN
            r_sticky <= r_sticky | (|r_y_man);
`endif
          end else begin
            r_y_man  <= r_y_man >> 1;
            r_d      <= r_d - EXP_W'(1);
`ifdef FP_ALIGN_STICKY_EN
            r_sticky <= r_sticky | r_y_man[0];
`endif
          end
        end
        ADD: begin
          r_out_val   <= w_result;
          r_out_exp   <= r_x_exp;
          r_out_valid <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_val   = r_out_val;
  assign bus.out_exp   = r_out_exp;

endmodule

// File: tb/tb_fp_align_add.sv
// Directed self-checking bench for fp_align_add (MAN_W=23, EXP_W=8).
module tb_fp_align_add;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned EXP_W = 8;
`ifdef FP_ALIGN_STICKY_EN
  localparam logic [25:0] ST = 26'h1;
`else
  localparam logic [25:0] ST = 26'h0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_align_add_if #(.MAN_W(MAN_W), .EXP_W(EXP_W)) bus();

  fp_align_add #(.MAN_W(MAN_W), .EXP_W(EXP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic as, input logic [7:0] ae, input logic [22:0] am,
                       input logic bs, input logic [7:0] be, input logic [22:0] bm,
                       input logic sb);
    bus.a_sign   = as;
    bus.a_exp    = ae;
    bus.a_man    = am;
    bus.b_sign   = bs;
    bus.b_exp    = be;
    bus.b_man    = bm;
    bus.sub      = sb;
    bus.in_valid = 1'b1;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag,
                        input logic as, input logic [7:0] ae, input logic [22:0] am,
                        input logic bs, input logic [7:0] be, input logic [22:0] bm,
                        input logic sb, input int lat,
                        input logic [25:0] ev, input logic [7:0] ee);
    int n;
    chk({tag, ".in_ready"}, bus.in_ready, 1);
    drive(as, ae, am, bs, be, bm, sb);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(n);
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".out_val"}, bus.out_val, ev);
    chk({tag, ".out_exp"}, bus.out_exp, ee);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".valid_drop"}, bus.out_valid, 0);
    chk({tag, ".idle"}, bus.in_ready, 1);
  endtask

  initial begin
    int n;
    int ones;
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'd0, 23'h0, 1'b0, 8'd0, 23'h0, 1'b0);
    bus.in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_val", bus.out_val, 0);
    chk("rst.out_exp", bus.out_exp, 0);
    chk("rst.in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add11",  0, 127, 23'h400000, 0, 127, 23'h400000, 0, 1,  26'h0800000, 127);
    run_op("sub15",  0, 127, 23'h600000, 0, 127, 23'h600000, 1, 1,  26'h2000000, 127);
    run_op("add1q",  0, 127, 23'h400000, 0, 125, 23'h400000, 0, 3,  26'h0500000, 127);
    run_op("sub12",  0, 127, 23'h400000, 0, 128, 23'h400000, 1, 2,  26'h1200000, 128);
    run_op("big40",  0, 167, 23'h400000, 0, 127, 23'h400000, 0, 2,  26'h0400000 | ST, 167);
    run_op("d23",    0, 150, 23'h400000, 0, 127, 23'h400000, 0, 24, 26'h0400000 | ST, 150);
    run_op("d24",    0, 151, 23'h400000, 0, 127, 23'h400000, 0, 2,  26'h0400000 | ST, 151);
    run_op("negadd", 1, 127, 23'h400000, 1, 127, 23'h400000, 0, 1,  26'h1800000, 127);
    run_op("zeroA",  0, 200, 23'h000000, 0, 127, 23'h400000, 0, 2,  26'h0400000, 127);
    run_op("subneg", 0, 127, 23'h400000, 1, 127, 23'h400000, 1, 1,  26'h0800000, 127);

    // Backpressure: hold result while a second operand pair is offered.
    drive(0, 127, 23'h400000, 0, 127, 23'h400000, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_out(n);
    chk("bp.latency", n, 1);
    drive(0, 127, 23'h600000, 0, 127, 23'h600000, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.out_val", bus.out_val, 26'h0800000);
      chk("bp.out_valid", bus.out_valid, 1);
      chk("bp.in_ready", bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp.valid_drop", bus.out_valid, 0);
    chk("bp.idle", bus.in_ready, 1);
    @(posedge clk); #1;
    chk("bp.ignored", bus.out_valid, 0);

    // Reset while aligning a d=10 operation.
    drive(0, 137, 23'h400000, 0, 127, 23'h400000, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst.in_ready", bus.in_ready, 1);
    ones = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ones++;
    end
    chk("mrst.no_valid", ones, 0);
    chk("mrst.in_ready2", bus.in_ready, 1);
    run_op("post", 0, 127, 23'h400000, 0, 127, 23'h400000, 0, 1, 26'h0800000, 127);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
